// File: rtl/data_mem_pipe.sv
// -----------------------------------------------------------------------------
// data_mem_pipe
//
// Single-port synchronous data memory for the CPU load/store path.
//   - Configurable word width and depth, per-lane write masks.
//   - Reads sample the array at acceptance and return through a
//     READ_LATENCY-deep valid/data pipeline; read_valid pulses for one cycle
//     and read_data holds until the next read returns.
//   - A clear engine sweeps the whole array to zero, one word per cycle,
//     while busy is high. Requests presented during the sweep are dropped.
//
// Parameters:
//   DATA_WIDTH    word width in bits (multiple of LANE_WIDTH)
//   LANE_WIDTH    write-mask granularity in bits
//   ADDRESS_WIDTH address bits, depth = 2**ADDRESS_WIDTH
//   READ_LATENCY  cycles from accepted read to read_valid, legal 1..4
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   cs             request strobe
//   read_not_write 1 = read, 0 = write (sampled with cs)
//   address        word address
//   write_data     write word
//   write_mask     per-lane write enable, bit i covers lane i
//   clear          one-cycle pulse starting the zero sweep
//   read_data      read result, held between reads
//   read_valid     one-cycle strobe marking new read_data
//   busy           clear sweep in progress
// -----------------------------------------------------------------------------
module data_mem_pipe #(
    parameter int DATA_WIDTH    = 24,
    parameter int LANE_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int READ_LATENCY  = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cs,
    input  logic                             read_not_write,
    input  logic [ADDRESS_WIDTH-1:0]         address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] write_mask,
    input  logic                             clear,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             read_valid,
    output logic                             busy
);

    localparam int LANES     = DATA_WIDTH / LANE_WIDTH;
    localparam int NUM_WORDS = 2 ** ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // Clear engine state
    // -------------------------------------------------------------------------
    state_e                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
    logic                       busy_w;

    assign busy_w = (state_q == ST_CLEAR);
    assign busy   = busy_w;

    // A request is taken only when the sweep is idle and no sweep is starting
    // in the same cycle.
    logic req_accept;
    logic rd_accept;
    logic wr_accept;

    assign req_accept = cs && !busy_w && !clear;
    assign rd_accept  = req_accept && read_not_write;
    assign wr_accept  = req_accept && !read_not_write;

    // NOTE: every output of a combinational block gets a default on entry so
    // that no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // The pointer wraps back to 0 naturally after the last word,
                // leaving it ready for the next sweep.
                clear_ptr_d = clear_ptr_q + ADDR_ONE;
                if (clear_ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same edge without ordering races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    // NOTE: the array has no reset on purpose; a reset port would stop it
    // mapping onto RAM macros, and a reset mid-sweep must leave already
    // zeroed and untouched words as they are.
    always_ff @(posedge clk) begin
        if (busy_w) begin
            mem_q[clear_ptr_q] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_mask[i]) begin
                    mem_q[address][i*LANE_WIDTH +: LANE_WIDTH] <=
                        write_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline: stage 0 captures the array at acceptance, the output
    // register is loaded READ_LATENCY edges after acceptance.
    // -------------------------------------------------------------------------
    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    read_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            pipe_valid_q[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data_q[0] <= mem_q[address];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
            read_valid_q <= pipe_valid_q[READ_LATENCY-1];
            // Hold the last returned word between reads.
            if (pipe_valid_q[READ_LATENCY-1]) begin
                read_data_q <= pipe_data_q[READ_LATENCY-1];
            end
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_data_mem_pipe
//
// Self-checking bench for data_mem_pipe (24-bit words, 8-bit lanes, 256 words,
// read latency 2). A behavioural model tracks memory contents, outstanding
// reads with their due edge, and the clear window as an edge range.
// -----------------------------------------------------------------------------
module tb_data_mem_pipe;

    localparam int DW = 24;
    localparam int LW = 8;
    localparam int AW = 8;
    localparam int RL = 2;
    localparam int NL = DW / LW;
    localparam int NW = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cs;
    logic          read_not_write;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic [NL-1:0] write_mask;
    logic          clear;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          busy;

    always #5 clk = ~clk;

    data_mem_pipe #(
        .DATA_WIDTH    (DW),
        .LANE_WIDTH    (LW),
        .ADDRESS_WIDTH (AW),
        .READ_LATENCY  (RL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cs             (cs),
        .read_not_write (read_not_write),
        .address        (address),
        .write_data     (write_data),
        .write_mask     (write_mask),
        .clear          (clear),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .busy           (busy)
    );

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic [DW-1:0] mem_m [NW];
    rd_t           rd_q [$];
    int            edge_n       = 0;
    bit            clear_active = 0;
    int            clear_edge   = 0;
    logic          exp_valid    = 1'b0;
    logic [DW-1:0] exp_data     = '0;
    int            busy_cycles  = 0;

    // busy is high after edges clear_edge .. clear_edge+NW-1.
    function automatic bit busy_after(input int e);
        return clear_active && (e >= clear_edge) && (e < clear_edge + NW);
    endfunction

    task automatic model_reset();
        rd_q.delete();
        clear_active = 0;
        exp_valid    = 1'b0;
        exp_data     = '0;
    endtask

    task automatic model_edge();
        int            e;
        logic [DW-1:0] bm;
        e = ++edge_n;
        if (busy_after(e - 1)) begin
            // Word k is zeroed at clear_edge+1+k.
            mem_m[e - clear_edge - 1] = '0;
        end else if (clear) begin
            clear_active = 1;
            clear_edge   = e;
        end else if (cs) begin
            if (read_not_write) begin
                rd_q.push_back('{data: mem_m[address], due: e + RL});
            end else begin
                bm = {{LW{write_mask[2]}}, {LW{write_mask[1]}}, {LW{write_mask[0]}}};
                mem_m[address] = (mem_m[address] & ~bm) | (write_data & bm);
            end
        end
        exp_valid = 1'b0;
        if (rd_q.size() > 0 && rd_q[0].due == e) begin
            exp_valid = 1'b1;
            exp_data  = rd_q[0].data;
            void'(rd_q.pop_front());
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("read_valid", read_valid, exp_valid);
        check("read_data", read_data, exp_data);
        check("busy", busy, busy_after(edge_n));
        if (busy) busy_cycles++;
    endtask

    task automatic drive(input logic c, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NL-1:0] m, input logic cl);
        cs             = c;
        read_not_write = r;
        address        = a;
        write_data     = d;
        write_mask     = m;
        clear          = cl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wait_not_busy();
        int guard = 0;
        while (busy && guard < 400) begin
            step();
            guard++;
        end
        check("busy_timeout", guard < 400, 1);
    endtask

    // -------------------------------------------------------------------------
    // Directed vectors: inputs before edge k, expected outputs after edge k.
    // -------------------------------------------------------------------------
    typedef struct {
        logic          cs;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NL-1:0] mask;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] got [16];
        int            n_got;
        int            zero_cnt;
        int            vcnt;

        //            cs  rnw addr    wdata        mask    v   data
        vecs[0]  = '{1'b1, 1'b0, 8'd16, 24'hABCDEF, 3'b111, 1'b0, 24'h000000};
        vecs[1]  = '{1'b1, 1'b1, 8'd16, 24'h000000, 3'b000, 1'b0, 24'h000000};
        vecs[2]  = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b0, 24'h000000};
        vecs[3]  = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b1, 24'hABCDEF};
        vecs[4]  = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b0, 24'hABCDEF};
        vecs[5]  = '{1'b1, 1'b0, 8'd32, 24'h112233, 3'b111, 1'b0, 24'hABCDEF};
        vecs[6]  = '{1'b1, 1'b0, 8'd32, 24'hFFFFFF, 3'b010, 1'b0, 24'hABCDEF};
        vecs[7]  = '{1'b1, 1'b0, 8'd32, 24'h000000, 3'b000, 1'b0, 24'hABCDEF};
        vecs[8]  = '{1'b1, 1'b1, 8'd32, 24'h000000, 3'b000, 1'b0, 24'hABCDEF};
        vecs[9]  = '{1'b1, 1'b0, 8'd1,  24'h00000A, 3'b111, 1'b0, 24'hABCDEF};
        vecs[10] = '{1'b1, 1'b0, 8'd2,  24'h000014, 3'b111, 1'b1, 24'h11FF33};
        vecs[11] = '{1'b1, 1'b0, 8'd3,  24'h00001E, 3'b111, 1'b0, 24'h11FF33};
        vecs[12] = '{1'b1, 1'b1, 8'd1,  24'h000000, 3'b000, 1'b0, 24'h11FF33};
        vecs[13] = '{1'b1, 1'b1, 8'd2,  24'h000000, 3'b000, 1'b0, 24'h11FF33};
        vecs[14] = '{1'b1, 1'b1, 8'd3,  24'h000000, 3'b000, 1'b1, 24'h00000A};
        vecs[15] = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b1, 24'h000014};
        vecs[16] = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b1, 24'h00001E};
        vecs[17] = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b0, 24'h00001E};
        vecs[18] = '{1'b1, 1'b0, 8'd7,  24'h123456, 3'b111, 1'b0, 24'h00001E};
        vecs[19] = '{1'b1, 1'b1, 8'd7,  24'h000000, 3'b000, 1'b0, 24'h00001E};
        vecs[20] = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b0, 24'h00001E};
        vecs[21] = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b1, 24'h123456};
        vecs[22] = '{1'b0, 1'b0, 8'd0,  24'h000000, 3'b000, 1'b0, 24'h123456};

        // ---- reset state ----
        reset_n = 1'b0;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_read_data", read_data, 24'h0);
        check("reset_read_valid", read_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // ---- table: full/masked/no-op writes, latency, back-to-back reads ----
        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].cs, vecs[k].rnw, vecs[k].addr, vecs[k].wdata, vecs[k].mask, 1'b0);
            step();
            check($sformatf("vec%0d_valid", k), read_valid, vecs[k].exp_valid);
            check($sformatf("vec%0d_data", k), read_data, vecs[k].exp_data);
        end

        // ---- clear with a read in flight, requests dropped while busy ----
        drive(1'b1, 1'b0, 8'd5, 24'h000055, 3'b111, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'd5, '0, '0, 1'b0);
        step();
        busy_cycles = 0;
        drive(1'b1, 1'b1, 8'd16, '0, '0, 1'b1);          // same-cycle request dropped
        step();
        idle();
        step();
        check("inflight_valid", read_valid, 1'b1);
        check("inflight_data", read_data, 24'h000055);
        step();
        drive(1'b1, 1'b0, 8'd1, 24'hAAAAAA, 3'b111, 1'b0); // word 1 already zeroed
        step();
        drive(1'b1, 1'b1, 8'd1, '0, '0, 1'b0);
        step();
        check("busy_read_dropped", read_valid, 1'b0);
        idle();
        wait_not_busy();
        check("clear_busy_cycles", busy_cycles, NW);

        zero_cnt = 0;
        for (int k = 0; k < NW + RL; k++) begin
            if (k < NW) drive(1'b1, 1'b1, k[AW-1:0], '0, '0, 1'b0);
            else idle();
            step();
            if (read_valid && read_data == '0) zero_cnt++;
        end
        check("clear_all_zero", zero_cnt, NW);

        // ---- reset at cycle 5 of the sweep ----
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, k[AW-1:0], 24'h100000 | (k * 24'h111), 3'b111, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        step();
        idle();
        for (int k = 0; k < 5; k++) step();
        reset_n = 1'b0;
        #1;
        check("rst_clear_busy", busy, 1'b0);
        check("rst_clear_valid", read_valid, 1'b0);
        check("rst_clear_data", read_data, 24'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_got = 0;
        for (int k = 0; k < 16 + RL; k++) begin
            if (k < 16) drive(1'b1, 1'b1, k[AW-1:0], '0, '0, 1'b0);
            else idle();
            step();
            if (read_valid && n_got < 16) begin
                got[n_got] = read_data;
                n_got++;
            end
        end
        check("rst_clear_reads", n_got, 16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("rst_clear_word%0d", k), got[k],
                  (k < 5) ? 24'h0 : (24'h100000 | (k * 24'h111)));
        end

        // ---- reset with reads in flight ----
        drive(1'b1, 1'b0, 8'd7, 24'h777777, 3'b111, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'd7, '0, '0, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'd8, '0, '0, 1'b0);
        step();
        idle();
        reset_n = 1'b0;
        #1;
        check("rst_read_valid", read_valid, 1'b0);
        check("rst_read_busy", busy, 1'b0);
        check("rst_read_data", read_data, 24'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (read_valid) vcnt++;
        end
        check("rst_read_cancelled", vcnt, 0);

        // ---- randomized traffic against the model ----
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        step();
        idle();
        wait_not_busy();
        for (int k = 0; k < 700; k++) begin
            drive(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 16),
                  DW'($urandom), NL'($urandom), ($urandom % 250) == 0);
            step();
        end
        idle();
        for (int k = 0; k < RL + 1; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised single-port synchronous data memory: the next-generation data store behind the CPU's load/store path. It adds configurable width and depth, per-lane write masks, a configurable pipelined read latency with a `read_valid` strobe, and a hardware clear engine that zeroes the whole array. The block sits between the datapath's memory stage and the data bus, in place of the fixed-size word memory.

## Interface
- `DATA_WIDTH`, 24: word width in bits; must be a multiple of `LANE_WIDTH`.
- `LANE_WIDTH`, 8: write-mask granularity in bits; `LANES = DATA_WIDTH/LANE_WIDTH`.
- `ADDRESS_WIDTH`, 8: address bits; depth `NUM_WORDS = 2**ADDRESS_WIDTH`.
- `READ_LATENCY`, 2: cycles from accepted read to `read_valid`; legal range 1..4.

Ports:
- `clk` input 1: the single clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cs` input 1: request strobe, one request per cycle when high.
- `read_not_write` input 1: 1 = read, 0 = write; sampled with `cs`.
- `address` input `ADDRESS_WIDTH`: word address.
- `write_data` input `DATA_WIDTH`: write word.
- `write_mask` input `LANES`: bit i enables lane i (`write_data[i*LANE_WIDTH +: LANE_WIDTH]`).
- `clear` input 1: one-cycle pulse that starts a full-array zero sweep.
- `read_data` output `DATA_WIDTH`: read result, held until the next read returns.
- `read_valid` output 1: one-cycle strobe marking new `read_data`.
- `busy` output 1: clear sweep in progress; requests are not accepted.

## Operation
- Request accepted on a rising edge when `cs=1`, `busy=0` and `clear=0`. Requests presented while `busy=1` are dropped silently.
- Write: lanes with `write_mask[i]=1` are updated and other lanes keep their contents. `write_mask=0` is a legal no-op.
- Read: the array is read at acceptance. The result travels through a `READ_LATENCY`-deep valid/data pipeline.
- `read_data` is never tristated. It holds its last value between reads.
- Ordering: a read accepted in the cycle after a write to the same address returns the new data. Pipelined reads return in issue order, at most one per cycle. Back-to-back reads give back-to-back `read_valid`.
- Clear state machine:
  - IDLE → CLEAR on `clear=1` while IDLE; `cs` in the same cycle is dropped.
  - CLEAR writes zero to `clear_ptr`, starting at 0 and incrementing by 1 each cycle.
  - CLEAR → IDLE after writing `NUM_WORDS-1`; the pointer wraps to 0.
  - `clear` while in CLEAR is ignored.
- Reads already in flight when CLEAR starts complete normally with their pre-clear data.
- Memory array contents are not reset; they are undefined until written or cleared.

## Timing
- Reset (`reset_n=0`, asynchronous) sets:
  - `read_data=0`, `read_valid=0`, `busy=0`;
  - all pipeline valid bits to 0, `clear_ptr=0`, state IDLE.
- Release of reset is synchronised by the system; the first request may be issued on the first edge after release.
- Reset asserted mid-read cancels all in-flight reads, with no `read_valid`.
- Reset asserted mid-clear aborts the sweep; words already zeroed stay zero and the rest are unchanged.
- Read accepted at edge N: `read_valid=1` and `read_data` updated after edge N+`READ_LATENCY`, for exactly one cycle.
- Write accepted at edge N: the array is updated at edge N.
- Clear pulse sampled at edge N: `busy=1` from after edge N through the cycle containing the last write. Word k is zeroed at edge N+1+k. `busy=0` after edge N+`NUM_WORDS`, and the first new request is accepted at edge N+`NUM_WORDS`+1.

## Test plan
- Reset with `READ_LATENCY=2`: check `read_data=0`, `read_valid=0`, `busy=0`. Write 24'hABCDEF to address 16 with mask 3'b111, then read 16 → 24'hABCDEF with `read_valid` exactly 2 cycles after acceptance.
- Masked write: address 32 holds 24'h112233; write 24'hFFFFFF with mask 3'b010 → read returns 24'h11FF33. A write with mask 3'b000 leaves the word unchanged.
- Back-to-back reads of addresses 1, 2, 3 (holding 10, 20, 30) on consecutive cycles → three consecutive `read_valid` pulses with data 10, 20, 30 in order. `read_data` stays at 30 afterwards.
- Clear with `ADDRESS_WIDTH=4`:
  - pulse `clear` → `busy` high for 16 cycles;
  - a write issued during `busy` is dropped;
  - reading all 16 words afterwards returns 0.
- Clear with a read to address 5 (holding 24'h000055) issued one cycle before `clear` → `read_valid` still returns 24'h000055.
- `reset_n` pulsed low at cycle 5 of the clear sweep, and again with a read in flight → `busy=0` and `read_valid=0` immediately. Words 0–4 read 0 and words 5+ keep prior values.
